// File: rtl/i2s_rx_master_v2.sv
// I2S receive master: MCLK-derived BCLK/LRCLK, slot deserialiser,
// slice/saturate to OUT_WIDTH and a show-ahead sample FIFO.
module i2s_rx_master_v2 #(
   parameter int BCLK_HALF      = 4,
   parameter int SLOT_BITS      = 32,
   parameter int I2S_DATA_WIDTH = 24,
   parameter int OUT_WIDTH      = 12,
   parameter int OUT_LSB        = 7,
   parameter int SATURATE       = 1,
   parameter int STEREO         = 0,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                 MCLK,
   input  logic                 MCLK_rst_n,
   input  logic                 en,
   input  logic                 ADC_SDATA,
   output logic                 BCLK,
   output logic                 LRCLK,
   output logic [OUT_WIDTH-1:0] m_data,
   output logic                 m_chan,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic                 overrun,
   input  logic                 clr_overrun
);

   localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
   localparam int BIT_W = $clog2(2 * SLOT_BITS);
   localparam int AW    = $clog2(FIFO_DEPTH);
   // only the bits at and above OUT_LSB are ever kept
   localparam int NB    = I2S_DATA_WIDTH - OUT_LSB;
   localparam int HI_W  = NB - OUT_WIDTH + 1;

   localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(BCLK_HALF - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
   localparam logic [BIT_W-1:0] SLOT_C   = BIT_W'(SLOT_BITS);
   localparam logic [BIT_W-1:0] K_ONE    = BIT_W'(1);
   localparam logic [BIT_W-1:0] CAP_LAST = BIT_W'(NB);
   localparam logic [BIT_W-1:0] WORD_END = BIT_W'(I2S_DATA_WIDTH);

   localparam logic [OUT_WIDTH-1:0] SAT_MAX =
      {1'b0, {(OUT_WIDTH-1){1'b1}}};
   localparam logic [OUT_WIDTH-1:0] SAT_MIN =
      {1'b1, {(OUT_WIDTH-1){1'b0}}};

   logic [DIV_W-1:0]     r_div;
   logic                 r_bclk;
   logic [BIT_W-1:0]     r_bit;
   logic                 r_lr;
   logic [NB-1:0]        r_shift;
   logic [NB-1:0]        r_word;
   logic                 r_wchan;
   logic                 r_push;
   logic [AW:0]          r_wptr;
   logic [AW:0]          r_rptr;
   logic                 r_ovr;
   logic [OUT_WIDTH:0]   r_mem [FIFO_DEPTH];

   logic                 w_tc;
   logic                 w_rise;
   logic                 w_fall;
   logic [BIT_W-1:0]     w_bit_nxt;
   logic [BIT_W-1:0]     w_k;
   logic                 w_cap;
   logic                 w_last;
   logic [NB-1:0]        w_shift_nxt;
   logic [OUT_WIDTH-1:0] w_slice;
   logic [HI_W-1:0]      w_hi;
   logic                 w_sat;
   logic [OUT_WIDTH-1:0] w_sample;
   logic                 w_empty;
   logic                 w_full;
   logic                 w_pop;
   logic                 w_wr;
   logic                 w_drop;
   logic [OUT_WIDTH:0]   w_head;

   // divider terminal count, bit-edge strobes and slot position
   always_comb begin
      w_tc      = (r_div == DIV_TC);
      w_rise    = en && w_tc && !r_bclk;
      w_fall    = en && w_tc && r_bclk;
      w_bit_nxt = (r_bit == BIT_LAST) ? '0 : r_bit + 1'b1;
      w_k       = r_lr ? (r_bit - SLOT_C) : r_bit;
      w_cap     = w_rise && (w_k >= K_ONE) && (w_k <= CAP_LAST);
      w_last    = w_rise && (w_k == WORD_END);
      w_shift_nxt = w_cap ? {r_shift[NB-2:0], ADC_SDATA} : r_shift;
   end

   // BCLK divider; held low while disabled
   always_ff @(posedge MCLK or negedge MCLK_rst_n) begin
      if (!MCLK_rst_n) begin
         r_div  <= '0;
         r_bclk <= 1'b0;
      end else if (!en) begin
         r_div  <= '0;
         r_bclk <= 1'b0;
      end else if (w_tc) begin
         r_div  <= '0;
         r_bclk <= ~r_bclk;
      end else begin
         r_div  <= r_div + 1'b1;
      end
   end

   // bit counter and LRCLK, both advanced on BCLK falling edges
   always_ff @(posedge MCLK or negedge MCLK_rst_n) begin
      if (!MCLK_rst_n) begin
         r_bit <= '0;
         r_lr  <= 1'b0;
      end else if (!en) begin
         r_bit <= '0;
         r_lr  <= 1'b0;
      end else if (w_fall) begin
         r_bit <= w_bit_nxt;
         r_lr  <= (w_bit_nxt >= SLOT_C);
      end
   end

   // MSB-first shift of the kept bits; partial word dropped on disable
   always_ff @(posedge MCLK or negedge MCLK_rst_n) begin
      if (!MCLK_rst_n) begin
         r_shift <= '0;
      end else if (!en) begin
         r_shift <= '0;
      end else begin
         r_shift <= w_shift_nxt;
      end
   end

   // latch completed word and channel, request a push one cycle later
   always_ff @(posedge MCLK or negedge MCLK_rst_n) begin
      if (!MCLK_rst_n) begin
         r_word  <= '0;
         r_wchan <= 1'b0;
         r_push  <= 1'b0;
      end else begin
         r_push <= w_last && ((STEREO != 0) || !r_lr);
         if (w_last) begin
            r_word  <= w_shift_nxt;
            r_wchan <= r_lr;
         end
      end
   end

   // slice with optional saturation when dropped MSBs are not sign copies
   always_comb begin
      w_slice  = r_word[OUT_WIDTH-1:0];
      w_hi     = r_word[NB-1:OUT_WIDTH-1];
      w_sat    = (SATURATE != 0) && !((&w_hi) || !(|w_hi));
      w_sample = w_slice;
      if (w_sat) begin
         w_sample = r_word[NB-1] ? SAT_MIN : SAT_MAX;
      end
   end

   // FIFO status and handshake decode
   always_comb begin
      w_empty = (r_wptr == r_rptr);
      w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
      w_pop   = !w_empty && m_ready;
      w_wr    = r_push && (!w_full || w_pop);
      w_drop  = r_push && w_full && !w_pop;
   end

   // FIFO pointers with wrap bit
   always_ff @(posedge MCLK or negedge MCLK_rst_n) begin
      if (!MCLK_rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_wr) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
      end
   end

   // FIFO storage; contents are only observed while non-empty
   always_ff @(posedge MCLK) begin
      if (w_wr) begin
         r_mem[r_wptr[AW-1:0]] <= {r_wchan, w_sample};
      end
   end

   // sticky overrun; a new drop wins over a clear
   always_ff @(posedge MCLK or negedge MCLK_rst_n) begin
      if (!MCLK_rst_n) begin
         r_ovr <= 1'b0;
      end else if (w_drop) begin
         r_ovr <= 1'b1;
      end else if (clr_overrun) begin
         r_ovr <= 1'b0;
      end
   end

   // show-ahead head of FIFO, zero while empty
   always_comb begin
      w_head  = r_mem[r_rptr[AW-1:0]];
      m_valid = !w_empty;
      m_data  = '0;
      m_chan  = 1'b0;
      if (!w_empty) begin
         m_data = w_head[OUT_WIDTH-1:0];
         m_chan = w_head[OUT_WIDTH];
      end
   end

   assign BCLK    = r_bclk;
   assign LRCLK   = r_lr;
   assign overrun = r_ovr;

endmodule

// File: tb/tb_i2s_rx_master_v2.sv
// Directed bench for i2s_rx_master_v2: three instances (mono/saturate,
// mono/truncate, stereo/saturate) driven from one serial stream.
module tb_i2s_rx_master_v2;

   logic MCLK = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;
   logic sd = 1'b1;
   logic clr = 1'b0;
   logic rdy_a = 1'b0;
   logic rdy_s = 1'b0;

   logic a_bclk, a_lr, a_chan, a_valid, a_ovr;
   logic b_bclk, b_lr, b_chan, b_valid, b_ovr;
   logic s_bclk, s_lr, s_chan, s_valid, s_ovr;
   logic [11:0] a_data, b_data, s_data;

   int checks = 0;
   int errors = 0;
   int t = 0;
   logic [23:0] lw [16];
   logic [23:0] rw [16];

   i2s_rx_master_v2 #(.SATURATE(1), .STEREO(0)) u_dut (
      .MCLK(MCLK), .MCLK_rst_n(rst_n), .en(en), .ADC_SDATA(sd),
      .BCLK(a_bclk), .LRCLK(a_lr), .m_data(a_data), .m_chan(a_chan),
      .m_valid(a_valid), .m_ready(rdy_a), .overrun(a_ovr),
      .clr_overrun(clr));

   i2s_rx_master_v2 #(.SATURATE(0), .STEREO(0)) u_tr (
      .MCLK(MCLK), .MCLK_rst_n(rst_n), .en(en), .ADC_SDATA(sd),
      .BCLK(b_bclk), .LRCLK(b_lr), .m_data(b_data), .m_chan(b_chan),
      .m_valid(b_valid), .m_ready(rdy_a), .overrun(b_ovr),
      .clr_overrun(clr));

   i2s_rx_master_v2 #(.SATURATE(1), .STEREO(1)) u_st (
      .MCLK(MCLK), .MCLK_rst_n(rst_n), .en(en), .ADC_SDATA(sd),
      .BCLK(s_bclk), .LRCLK(s_lr), .m_data(s_data), .m_chan(s_chan),
      .m_valid(s_valid), .m_ready(rdy_s), .overrun(s_ovr),
      .clr_overrun(clr));

   always #5 MCLK = ~MCLK;

   // MCLK edges since enable/reset release
   always @(posedge MCLK) t <= (rst_n && en) ? t + 1 : 0;

   // serial source: bit for the rise at the coming edge; idle bits are 1
   always @(negedge MCLK) begin
      int tn, n, bc, f, k;
      logic [23:0] w;
      tn = t + 1;
      if (tn % 8 == 4) begin
         n  = (tn - 4) / 8;
         bc = n % 64;
         f  = (n / 64) % 16;
         k  = bc % 32;
         w  = (bc >= 32) ? rw[f] : lw[f];
         sd = (k >= 1 && k <= 24) ? w[24-k] : 1'b1;
      end
   end

   task automatic wait_t(input int tt);
      int g = 0;
      while (t != tt && g < 20000) begin
         @(negedge MCLK);
         g++;
      end
      if (t != tt) begin
         checks++; errors++;
         $display("FAIL wait_t t=%0d want %0d", t, tt);
      end
   endtask

   task automatic test_reset;
      int bad = 0;
      rst_n = 1'b0;
      repeat (3) @(negedge MCLK);
      checks++;
      if ({a_bclk, a_lr, a_valid, a_chan, a_data, a_ovr} !== 17'h0) begin
         errors++;
         $display("FAIL reset_a got %h exp 0",
                  {a_bclk, a_lr, a_valid, a_chan, a_data, a_ovr});
      end
      checks++;
      if ({s_bclk, s_lr, s_valid, s_chan, s_data, s_ovr} !== 17'h0) begin
         errors++;
         $display("FAIL reset_s got %h exp 0",
                  {s_bclk, s_lr, s_valid, s_chan, s_data, s_ovr});
      end
      rst_n = 1'b1;
      repeat (12) begin
         @(negedge MCLK);
         if (a_bclk !== 1'b0 || a_lr !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL en_low_clocks got %0d toggles exp 0", bad);
      end
   endtask

   task automatic test_clocks;
      int bad = 0;
      logic eb, el;
      en = 1'b1;
      for (int i = 1; i <= 520; i++) begin
         @(negedge MCLK);
         eb = ((t / 4) % 2) == 1;
         el = ((t / 8) % 64) >= 32;
         if (a_bclk !== eb || a_lr !== el) bad++;
         if (t == 196) begin
            checks++;
            if (a_valid !== 1'b0) begin
               errors++;
               $display("FAIL early_push got %b exp 0", a_valid);
            end
         end
         if (t == 197) begin
            checks++;
            if ({a_valid, a_chan, a_data} !== {2'b10, 12'h7FF}) begin
               errors++;
               $display("FAIL first_sat got %h exp %h",
                        {a_valid, a_chan, a_data}, {2'b10, 12'h7FF});
            end
            checks++;
            if ({b_valid, b_chan, b_data} !== {2'b10, 12'h468}) begin
               errors++;
               $display("FAIL first_trunc got %h exp %h",
                        {b_valid, b_chan, b_data}, {2'b10, 12'h468});
            end
         end
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL bclk_lrclk_timing got %0d bad cycles exp 0", bad);
      end
   endtask

   task automatic test_mono;
      rdy_a = 1'b1;
      @(negedge MCLK);
      checks++;
      if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
         errors++;
         $display("FAIL mono_no_right got %b%b exp 00", a_valid, b_valid);
      end
   endtask

   task automatic test_stereo;
      logic [13:0] e0 [4];
      e0[0] = {2'b10, 12'h7FF};
      e0[1] = {2'b11, 12'h800};
      e0[2] = {2'b10, 12'hFFF};
      e0[3] = {2'b11, 12'h800};
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({s_valid, s_chan, s_data} !== e0[i]) begin
            errors++;
            $display("FAIL stereo_f0_%0d got %h exp %h", i,
                     {s_valid, s_chan, s_data}, e0[i]);
         end
         rdy_s = 1'b1; @(negedge MCLK); rdy_s = 1'b0;
      end
      wait_t(709);
      checks++;
      if ({a_valid, a_chan, a_data, b_data} !== {2'b10, 24'hFFFFFF}) begin
         errors++;
         $display("FAIL mono_f1 got %h exp %h",
                  {a_valid, a_chan, a_data, b_data}, {2'b10, 24'hFFFFFF});
      end
      wait_t(965);
      for (int i = 2; i < 4; i++) begin
         checks++;
         if ({s_valid, s_chan, s_data} !== e0[i]) begin
            errors++;
            $display("FAIL stereo_f1_%0d got %h exp %h", i,
                     {s_valid, s_chan, s_data}, e0[i]);
         end
         rdy_s = 1'b1; @(negedge MCLK); rdy_s = 1'b0;
      end
      checks++;
      if (s_valid !== 1'b0) begin
         errors++;
         $display("FAIL stereo_empty got %b exp 0", s_valid);
      end
   endtask

   task automatic test_overrun;
      wait_t(2244);
      checks++;
      if ({s_valid, s_ovr} !== 2'b10) begin
         errors++;
         $display("FAIL ovr_before got %b exp 10", {s_valid, s_ovr});
      end
      wait_t(2245);
      checks++;
      if (s_ovr !== 1'b1) begin
         errors++;
         $display("FAIL ovr_set got %b exp 1", s_ovr);
      end
      wait_t(2510);
      for (int i = 0; i < 4; i++) begin
         logic [13:0] e;
         e = {1'b1, i[0], 12'(i + 1)};
         checks++;
         if ({s_valid, s_chan, s_data} !== e) begin
            errors++;
            $display("FAIL ovr_pop%0d got %h exp %h", i,
                     {s_valid, s_chan, s_data}, e);
         end
         rdy_s = 1'b1; @(negedge MCLK); rdy_s = 1'b0;
      end
      checks++;
      if ({s_valid, s_ovr, a_ovr} !== 3'b010) begin
         errors++;
         $display("FAIL ovr_sticky got %b exp 010", {s_valid, s_ovr, a_ovr});
      end
      clr = 1'b1; @(negedge MCLK); clr = 1'b0;
      checks++;
      if (s_ovr !== 1'b0) begin
         errors++;
         $display("FAIL ovr_clear got %b exp 0", s_ovr);
      end
   endtask

   task automatic test_full_pop;
      logic [13:0] e [5];
      e[0] = {2'b10, 12'h007};
      e[1] = {2'b11, 12'h008};
      e[2] = {2'b10, 12'h009};
      e[3] = {2'b11, 12'h00A};
      e[4] = {2'b10, 12'h00B};
      wait_t(3780);
      checks++;
      if ({s_valid, s_chan, s_data} !== e[0]) begin
         errors++;
         $display("FAIL full_head got %h exp %h",
                  {s_valid, s_chan, s_data}, e[0]);
      end
      rdy_s = 1'b1; @(negedge MCLK); rdy_s = 1'b0;
      checks++;
      if (s_ovr !== 1'b0) begin
         errors++;
         $display("FAIL full_pop_ovr got %b exp 0", s_ovr);
      end
      for (int i = 1; i < 5; i++) begin
         checks++;
         if ({s_valid, s_chan, s_data} !== e[i]) begin
            errors++;
            $display("FAIL full_pop%0d got %h exp %h", i,
                     {s_valid, s_chan, s_data}, e[i]);
         end
         rdy_s = 1'b1; @(negedge MCLK); rdy_s = 1'b0;
      end
      checks++;
      if (s_valid !== 1'b0) begin
         errors++;
         $display("FAIL full_drain got %b exp 0", s_valid);
      end
      wait_t(4037);
      checks++;
      if ({s_valid, s_chan, s_data} !== {2'b11, 12'h7FF}) begin
         errors++;
         $display("FAIL sat_pos_right got %h exp %h",
                  {s_valid, s_chan, s_data}, {2'b11, 12'h7FF});
      end
   endtask

   task automatic test_reset_mid;
      rdy_a = 1'b0;
      wait_t(4180);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({a_bclk, a_lr, a_valid, a_data, s_valid, s_ovr} !== 16'h0) begin
         errors++;
         $display("FAIL mid_reset got %h exp 0",
                  {a_bclk, a_lr, a_valid, a_data, s_valid, s_ovr});
      end
      lw[0] = 24'hABCDEF;
      rw[0] = 24'h000000;
      @(negedge MCLK);
      rst_n = 1'b1;
      wait_t(196);
      checks++;
      if (a_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_partial got %b exp 0", a_valid);
      end
      wait_t(197);
      checks++;
      if ({a_valid, a_chan, a_data, b_data} !== {2'b10, 24'h80079B}) begin
         errors++;
         $display("FAIL rst_next_word got %h exp %h",
                  {a_valid, a_chan, a_data, b_data}, {2'b10, 24'h80079B});
      end
   endtask

   task automatic test_en_drop;
      wait_t(612);
      en = 1'b0;
      repeat (4) @(negedge MCLK);
      checks++;
      if ({a_bclk, a_lr, a_valid, a_data} !== {3'b001, 12'h800}) begin
         errors++;
         $display("FAIL en_low_hold got %h exp %h",
                  {a_bclk, a_lr, a_valid, a_data}, {3'b001, 12'h800});
      end
      rdy_a = 1'b1; @(negedge MCLK); rdy_a = 1'b0;
      checks++;
      if ({a_valid, b_valid} !== 2'b00) begin
         errors++;
         $display("FAIL en_low_pop got %b exp 00", {a_valid, b_valid});
      end
      lw[0] = 24'h000F80;
      en = 1'b1;
      wait_t(196);
      checks++;
      if ({a_valid, b_valid} !== 2'b00) begin
         errors++;
         $display("FAIL en_partial got %b exp 00", {a_valid, b_valid});
      end
      wait_t(197);
      checks++;
      if ({a_valid, a_chan, a_data, b_data} !== {2'b10, 24'h01F01F}) begin
         errors++;
         $display("FAIL en_next_word got %h exp %h",
                  {a_valid, a_chan, a_data, b_data}, {2'b10, 24'h01F01F});
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         lw[i] = 24'h0;
         rw[i] = 24'h0;
      end
      lw[0] = 24'h123456; rw[0] = 24'h800000;
      lw[1] = 24'hFFFF80; rw[1] = 24'h800000;
      lw[2] = 24'h000080; rw[2] = 24'h000100;
      lw[3] = 24'h000180; rw[3] = 24'h000200;
      lw[4] = 24'h000280; rw[4] = 24'h000300;
      lw[5] = 24'h000380; rw[5] = 24'h000400;
      lw[6] = 24'h000480; rw[6] = 24'h000500;
      lw[7] = 24'h000580; rw[7] = 24'h7FFFFF;
      lw[8] = 24'hFFFFFF; rw[8] = 24'hFFFFFF;
      @(negedge MCLK);
      test_reset;
      test_clocks;
      test_mono;
      test_stereo;
      test_overrun;
      test_full_pop;
      lw[1] = 24'hFFFFFF;
      test_reset_mid;
      test_en_drop;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
